// File: rtl/adc_burst_framer.sv
// adc_burst_framer: turns ADC sample groups plus fill/trigger pulses into
// 132-bit tagged bursts {tag, payload}. A fill is one waveform header per
// trigger, the data bursts of each waveform, a fill header trailer and a
// checksum burst. Output is a single registered slot with valid/ready.
module adc_burst_framer #(
    parameter int ADC_BITS  = 12,
    parameter int CSUM_MODE = 0,
    parameter int CNT_W     = 23
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fill_start,
    input  logic                        fill_end,
    input  logic                        trig,
    input  logic [23:0]                 fill_num,
    input  logic [1:0]                  fill_type,
    input  logic [11:0]                 channel_tag,
    input  logic [13:0]                 num_bursts,
    input  logic [15:0]                 pre_trig,
    input  logic [3:0]                  xadc_alarms,
    input  logic [8*(ADC_BITS+1)-1:0]   din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic [131:0]                dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        busy,
    output logic [7:0]                  trig_drop_cnt,
    output logic [15:0]                 ovr_cnt
);

    localparam int SW = ADC_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WHDR,
        S_DATA,
        S_FHDR,
        S_CSUM
    } state_t;

    state_t             r_state;
    logic [131:0]       r_dout;
    logic               r_dout_valid;
    logic [23:0]        r_fill_num;
    logic [1:0]         r_fill_type;
    logic [11:0]        r_channel_tag;
    logic [13:0]        r_num_bursts;
    logic [15:0]        r_pre_trig;
    logic               r_pending;
    logic [13:0]        r_data_cnt;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic [CNT_W-1:0]   r_wfm_cnt;
    logic [127:0]       r_csum;
    logic [7:0]         r_trig_drop;
    logic [15:0]        r_ovr_cnt;

    logic               w_load;
    logic               w_din_take;
    logic               w_pend_now;
    logic [127:0]       w_data_payload;
    logic [7:0]         w_ovr_bits;
    logic [3:0]         w_ovr_pop;
    logic [16:0]        w_ovr_sum;
    logic [CNT_W-1:0]   w_final_cnt;
    logic [22:0]        w_burst23;
    logic [22:0]        w_final23;
    logic [22:0]        w_wfm23;
    logic [127:0]       w_wfm_hdr;
    logic [127:0]       w_fill_hdr;
    logic               w_emit;
    logic [3:0]         w_emit_tag;
    logic [127:0]       w_emit_payload;
    logic [127:0]       w_csum_upd;

    // The output slot can take a new burst when empty or being drained this cycle.
    assign w_load      = !r_dout_valid || dout_ready;
    assign w_din_take  = (r_state == S_DATA) && w_load && din_valid;
    assign w_pend_now  = r_pending || fill_end;
    assign din_ready   = (r_state == S_DATA) && w_load;
    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign busy        = (r_state != S_IDLE);
    assign trig_drop_cnt = r_trig_drop;
    assign ovr_cnt     = r_ovr_cnt;

    // Unpack each sample slot {sample, ovr} and sign-extend the sample into its lane.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign w_ovr_bits[gi] = din[gi*SW];
            assign w_data_payload[gi*16 +: 16] =
                {{(16-ADC_BITS){din[gi*SW + ADC_BITS]}}, din[gi*SW + 1 +: ADC_BITS]};
        end
    endgenerate

    // Number of overrange flags in the current group.
    always_comb begin
        w_ovr_pop = '0;
        for (int k = 0; k < 8; k++) begin
            w_ovr_pop = w_ovr_pop + {3'b000, w_ovr_bits[k]};
        end
    end

    assign w_ovr_sum   = {1'b0, r_ovr_cnt} + {13'd0, w_ovr_pop};
    // The trailer reports the count as it will stand after itself and the checksum.
    assign w_final_cnt = r_burst_cnt + CNT_W'(2);

    // Header count fields are 23 bits wide: zero-pad or truncate the counters.
    generate
        if (CNT_W >= 23) begin : g_cnt_trunc
            assign w_burst23 = r_burst_cnt[22:0];
            assign w_final23 = w_final_cnt[22:0];
            assign w_wfm23   = r_wfm_cnt[22:0];
        end else begin : g_cnt_pad
            assign w_burst23 = {{(23-CNT_W){1'b0}}, r_burst_cnt};
            assign w_final23 = {{(23-CNT_W){1'b0}}, w_final_cnt};
            assign w_wfm23   = {{(23-CNT_W){1'b0}}, r_wfm_cnt};
        end
    endgenerate

    // Waveform header and fill header payload layouts.
    always_comb begin
        w_wfm_hdr            = '0;
        w_wfm_hdr[13:0]      = r_num_bursts;
        w_wfm_hdr[25:14]     = r_pre_trig[11:0];
        w_wfm_hdr[51:26]     = {w_burst23, 3'd0};
        w_wfm_hdr[74:52]     = w_wfm23;
        w_wfm_hdr[109:98]    = r_channel_tag;
        w_wfm_hdr[113:110]   = xadc_alarms;
        w_wfm_hdr[127:126]   = 2'b01;

        w_fill_hdr           = '0;
        w_fill_hdr[23:0]     = r_fill_num;
        w_fill_hdr[25:24]    = r_fill_type;
        w_fill_hdr[26]       = 1'b1;
        w_fill_hdr[49:27]    = w_final23;
        w_fill_hdr[63:50]    = r_num_bursts;
        w_fill_hdr[75:64]    = r_pre_trig[11:0];
        w_fill_hdr[98:76]    = w_wfm23;
        w_fill_hdr[102:99]   = r_pre_trig[15:12];
        w_fill_hdr[121:110]  = r_channel_tag;
        w_fill_hdr[127:126]  = 2'b01;
    end

    // Select which burst (if any) the current state loads this cycle.
    always_comb begin
        w_emit         = 1'b0;
        w_emit_tag     = 4'd0;
        w_emit_payload = '0;
        case (r_state)
            S_WHDR: begin
                w_emit         = w_load;
                w_emit_tag     = 4'd2;
                w_emit_payload = w_wfm_hdr;
            end
            S_DATA: begin
                w_emit         = w_din_take;
                w_emit_tag     = 4'd3;
                w_emit_payload = w_data_payload;
            end
            S_FHDR: begin
                w_emit         = w_load;
                w_emit_tag     = 4'd1;
                w_emit_payload = w_fill_hdr;
            end
            S_CSUM: begin
                w_emit         = w_load;
                w_emit_tag     = 4'd4;
                w_emit_payload = r_csum;
            end
            default: begin
                w_emit         = 1'b0;
            end
        endcase
    end

    // Running checksum candidate: 128-bit XOR or four 32-bit lane sums.
    generate
        if (CSUM_MODE == 0) begin : g_csum_xor
            assign w_csum_upd = r_csum ^ w_emit_payload;
        end else begin : g_csum_sum
            for (gi = 0; gi < 4; gi++) begin : g_csum_lane
                assign w_csum_upd[gi*32 +: 32] = r_csum[gi*32 +: 32] + w_emit_payload[gi*32 +: 32];
            end
        end
    endgenerate

    // Sequencer, output slot, counters and checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_fill_num    <= '0;
            r_fill_type   <= '0;
            r_channel_tag <= '0;
            r_num_bursts  <= '0;
            r_pre_trig    <= '0;
            r_pending     <= 1'b0;
            r_data_cnt    <= '0;
            r_burst_cnt   <= '0;
            r_wfm_cnt     <= '0;
            r_csum        <= '0;
            r_trig_drop   <= '0;
            r_ovr_cnt     <= '0;
        end else begin
            if (w_emit) begin
                r_dout       <= {w_emit_tag, w_emit_payload};
                r_dout_valid <= 1'b1;
                r_burst_cnt  <= r_burst_cnt + CNT_W'(1);
                if (r_state != S_CSUM) begin
                    r_csum <= w_csum_upd;
                end
            end else if (dout_ready) begin
                r_dout_valid <= 1'b0;
            end

            if (trig && (r_state != S_ARMED) && (r_trig_drop != 8'hFF)) begin
                r_trig_drop <= r_trig_drop + 8'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (fill_start) begin
                        r_fill_num    <= fill_num;
                        r_fill_type   <= fill_type;
                        r_channel_tag <= channel_tag;
                        r_csum        <= '0;
                        r_burst_cnt   <= '0;
                        r_wfm_cnt     <= '0;
                        r_ovr_cnt     <= '0;
                        r_trig_drop   <= '0;
                        r_pending     <= 1'b0;
                        r_state       <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (trig) begin
                        r_num_bursts <= num_bursts;
                        r_pre_trig   <= pre_trig;
                        r_pending    <= w_pend_now;
                        r_state      <= S_WHDR;
                    end else if (fill_end) begin
                        r_state      <= S_FHDR;
                    end
                end
                S_WHDR: begin
                    if (fill_end) begin
                        r_pending <= 1'b1;
                    end
                    if (w_load) begin
                        r_wfm_cnt  <= r_wfm_cnt + CNT_W'(1);
                        r_data_cnt <= '0;
                        if (r_num_bursts == 14'd0) begin
                            r_state <= w_pend_now ? S_FHDR : S_ARMED;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (fill_end) begin
                        r_pending <= 1'b1;
                    end
                    if (w_din_take) begin
                        r_ovr_cnt  <= w_ovr_sum[16] ? 16'hFFFF : w_ovr_sum[15:0];
                        r_data_cnt <= r_data_cnt + 14'd1;
                        if ((r_data_cnt + 14'd1) == r_num_bursts) begin
                            r_state <= w_pend_now ? S_FHDR : S_ARMED;
                        end
                    end
                end
                S_FHDR: begin
                    if (w_load) begin
                        r_pending <= 1'b0;
                        r_state   <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (w_load) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_burst_framer.sv
// Bench for adc_burst_framer: two instances (XOR and lane-sum checksum) share
// directed stimulus; a burst-level model predicts every accepted burst.
module tb_adc_burst_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, fill_start, fill_end, trig;
    logic [23:0]  fill_num;
    logic [1:0]   fill_type;
    logic [11:0]  channel_tag;
    logic [13:0]  num_bursts;
    logic [15:0]  pre_trig;
    logic [3:0]   xadc_alarms;
    logic [103:0] din;
    logic         din_valid, dout_ready;

    logic         din_ready0, dout_valid0, busy0;
    logic [131:0] dout0;
    logic [7:0]   drop0;
    logic [15:0]  ovr0;
    logic         din_ready1, dout_valid1, busy1;
    logic [131:0] dout1;
    logic [7:0]   drop1;
    logic [15:0]  ovr1;

    adc_burst_framer #(.ADC_BITS(12), .CSUM_MODE(0), .CNT_W(23)) dut0 (
        .clk(clk), .rst(rst), .fill_start(fill_start), .fill_end(fill_end), .trig(trig),
        .fill_num(fill_num), .fill_type(fill_type), .channel_tag(channel_tag),
        .num_bursts(num_bursts), .pre_trig(pre_trig), .xadc_alarms(xadc_alarms),
        .din(din), .din_valid(din_valid), .din_ready(din_ready0),
        .dout(dout0), .dout_valid(dout_valid0), .dout_ready(dout_ready),
        .busy(busy0), .trig_drop_cnt(drop0), .ovr_cnt(ovr0));

    adc_burst_framer #(.ADC_BITS(12), .CSUM_MODE(1), .CNT_W(23)) dut1 (
        .clk(clk), .rst(rst), .fill_start(fill_start), .fill_end(fill_end), .trig(trig),
        .fill_num(fill_num), .fill_type(fill_type), .channel_tag(channel_tag),
        .num_bursts(num_bursts), .pre_trig(pre_trig), .xadc_alarms(xadc_alarms),
        .din(din), .din_valid(din_valid), .din_ready(din_ready1),
        .dout(dout1), .dout_valid(dout_valid1), .dout_ready(dout_ready),
        .busy(busy1), .trig_drop_cnt(drop1), .ovr_cnt(ovr1));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- burst-level model ----------------
    logic [131:0] q0[$], q1[$], acc0[$], acc1[$];
    logic [22:0]  m_bc, m_wfm;
    logic [127:0] m_x, m_s;
    logic [15:0]  m_ovr;
    logic [7:0]   m_drop;
    logic [23:0]  m_fnum;
    logic [1:0]   m_ftype;
    logic [11:0]  m_ctag;
    logic [13:0]  m_nb;
    logic [15:0]  m_pt;

    task automatic m_push(input logic [3:0] tag, input logic [127:0] p);
        q0.push_back({tag, p});
        q1.push_back({tag, p});
        m_x = m_x ^ p;
        for (int j = 0; j < 4; j++) m_s[j*32 +: 32] = m_s[j*32 +: 32] + p[j*32 +: 32];
        m_bc = m_bc + 23'd1;
    endtask

    task automatic m_fill_open(input logic [23:0] fn, input logic [1:0] ft, input logic [11:0] ct);
        m_fnum = fn; m_ftype = ft; m_ctag = ct;
        m_bc = '0; m_wfm = '0; m_x = '0; m_s = '0; m_ovr = '0; m_drop = '0;
    endtask

    task automatic m_wave(input logic [13:0] nb, input logic [15:0] pt, input logic [3:0] al);
        logic [127:0] p;
        m_nb = nb; m_pt = pt;
        p = '0;
        p[13:0] = nb; p[25:14] = pt[11:0]; p[51:26] = {m_bc, 3'd0}; p[74:52] = m_wfm;
        p[109:98] = m_ctag; p[113:110] = al; p[127:126] = 2'b01;
        m_push(4'd2, p);
        m_wfm = m_wfm + 23'd1;
    endtask

    task automatic m_data(input logic [103:0] g);
        logic [127:0] p;
        logic [11:0]  s;
        int           t;
        t = m_ovr;
        for (int k = 0; k < 8; k++) begin
            s = g[k*13+1 +: 12];
            p[k*16 +: 16] = {{4{s[11]}}, s};
            t = t + int'(g[k*13]);
        end
        m_ovr = (t > 65535) ? 16'hFFFF : t[15:0];
        m_push(4'd3, p);
    endtask

    task automatic m_close();
        logic [127:0] p;
        p = '0;
        p[23:0] = m_fnum; p[25:24] = m_ftype; p[26] = 1'b1; p[49:27] = m_bc + 23'd2;
        p[63:50] = m_nb; p[75:64] = m_pt[11:0]; p[98:76] = m_wfm; p[102:99] = m_pt[15:12];
        p[121:110] = m_ctag; p[127:126] = 2'b01;
        m_push(4'd1, p);
        q0.push_back({4'd4, m_x});
        q1.push_back({4'd4, m_s});
        m_bc = m_bc + 23'd1;
    endtask

    function automatic logic [103:0] grp(input logic [95:0] s, input logic [7:0] o);
        logic [103:0] g;
        for (int k = 0; k < 8; k++) g[k*13 +: 13] = {s[k*12 +: 12], o[k]};
        return g;
    endfunction

    // ---------------- compare process ----------------
    logic         prev_stall = 1'b0;
    logic [131:0] prev_dout = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_stall) begin
                    check("stall_dout_hold", dout0, prev_dout);
                    check("stall_valid_hold", {131'd0, dout_valid0}, 132'd1);
                end
                if (dout_valid0 && !dout_ready)
                    check("stall_din_ready", {131'd0, din_ready0}, 132'd0);
                if (dout_valid0 && dout_ready) begin
                    if (q0.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL burst0_unexpected: got %h expected none", dout0);
                    end else begin
                        check("burst0", dout0, q0.pop_front());
                        acc0.push_back(dout0);
                    end
                end
                if (dout_valid1 && dout_ready) begin
                    if (q1.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL burst1_unexpected: got %h expected none", dout1);
                    end else begin
                        check("burst1", dout1, q1.pop_front());
                        acc1.push_back(dout1);
                    end
                end
                prev_stall = dout_valid0 && !dout_ready;
                prev_dout  = dout0;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_group(input logic [103:0] g);
        bit ok;
        ok = 0;
        din = g;
        din_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (din_ready0) begin ok = 1; break; end
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL group_accept: got din_ready=0 for 60 cycles expected 1");
        end
    endtask

    task automatic fill_open(input logic [23:0] fn, input logic [1:0] ft, input logic [11:0] ct);
        acc0.delete(); acc1.delete();
        m_fill_open(fn, ft, ct);
        fill_num = fn; fill_type = ft; channel_tag = ct;
        fill_start = 1'b1; tick(); fill_start = 1'b0;
    endtask

    task automatic wave(input logic [13:0] nb, input logic [15:0] pt, input logic [3:0] al);
        m_wave(nb, pt, al);
        num_bursts = nb; pre_trig = pt; xadc_alarms = al;
        trig = 1'b1; tick(); trig = 1'b0;
    endtask

    task automatic end_fill();
        m_close();
        fill_end = 1'b1; tick(); fill_end = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (q0.size() == 0 && q1.size() == 0 && !dout_valid0) break;
        end
        check({name, "_drained"}, 132'(q0.size() + q1.size()), 132'd0);
        check({name, "_busy"}, {131'd0, busy0}, 132'd0);
        check({name, "_ovr_cnt"}, {116'd0, ovr0}, {116'd0, m_ovr});
        check({name, "_drop_cnt"}, {124'd0, drop0}, {124'd0, m_drop});
    endtask

    logic [103:0] ga, gb, gc, gm;
    logic [127:0] s1_csum;

    initial begin
        ga = grp({12'h555, 12'h000, 12'hABC, 12'h123, 12'h001, 12'h800, 12'h7FF, 12'hFFF}, 8'b0010_0101);
        gb = grp({12'h0F0, 12'h321, 12'hFED, 12'h7FE, 12'h400, 12'h3FF, 12'h00A, 12'h801}, 8'h00);
        gc = grp({12'h111, 12'h222, 12'h333, 12'h444, 12'h999, 12'hAAA, 12'hBBB, 12'hCCC}, 8'h00);
        gm = grp({8{12'hFFF}}, 8'h00);
        rst = 1'b1; fill_start = 0; fill_end = 0; trig = 0;
        fill_num = 0; fill_type = 0; channel_tag = 0; num_bursts = 0; pre_trig = 0;
        xadc_alarms = 0; din = 0; din_valid = 0; dout_ready = 1'b1;
        m_fill_open(24'd0, 2'd0, 12'd0);
        repeat (3) tick();
        check("rst_dout", dout0, 132'd0);
        check("rst_dout_valid", {131'd0, dout_valid0}, 132'd0);
        check("rst_din_ready", {131'd0, din_ready0}, 132'd0);
        check("rst_busy", {131'd0, busy0}, 132'd0);
        check("rst_counts", {108'd0, drop0, ovr0}, 132'd0);
        rst = 1'b0;
        tick();

        // Basic fill: tags 2,3,3,1,4
        fill_open(24'h00A5C3, 2'd2, 12'h3C7);
        wave(14'd2, 16'hB123, 4'h9);
        m_data(ga); send_group(ga);
        m_data(gb); send_group(gb);
        end_fill();
        s1_csum = m_x;
        drain("s1");
        check("s1_count", 132'(acc0.size()), 132'd5);
        check("s1_tags", {112'd0, acc0[0][131:128], acc0[1][131:128], acc0[2][131:128],
                          acc0[3][131:128], acc0[4][131:128]}, {112'd0, 20'h23314});
        check("s1_fhdr_burst", {109'd0, acc0[3][49:27]}, 132'd5);
        check("s1_fhdr_wfm", {109'd0, acc0[3][98:76]}, 132'd1);
        check("s1_whdr_pretrig", {120'd0, acc0[0][25:14]}, {120'd0, 12'h123});
        check("s1_whdr_alarm", {128'd0, acc0[0][113:110]}, 132'h9);
        check("s1_lane0_neg1", {116'd0, acc0[1][15:0]}, 132'hFFFF);
        check("s1_lane1_max", {116'd0, acc0[1][31:16]}, 132'h07FF);
        check("s1_lane2_min", {116'd0, acc0[1][47:32]}, 132'hF800);
        check("s1_ovr_cnt", {116'd0, ovr0}, 132'd3);

        // Same fill with a 5-cycle output stall mid-DATA
        fill_open(24'h00A5C3, 2'd2, 12'h3C7);
        wave(14'd2, 16'hB123, 4'h9);
        m_data(ga);
        din = ga; din_valid = 1'b1; dout_ready = 1'b0;
        repeat (5) tick();
        dout_ready = 1'b1;
        send_group(ga);
        m_data(gb); send_group(gb);
        end_fill();
        drain("s3");
        check("s3_csum_vs_nostall", {4'd0, acc0[4][127:0]}, {4'd0, s1_csum});

        // trig and fill_end during DATA
        fill_open(24'h000001, 2'd1, 12'h00F);
        wave(14'd3, 16'h0010, 4'h0);
        m_data(gb); send_group(gb);
        m_drop = m_drop + 8'd1;
        trig = 1'b1; tick(); trig = 1'b0;
        fill_end = 1'b1; tick(); fill_end = 1'b0;
        m_data(gc); send_group(gc);
        m_data(ga); send_group(ga);
        m_close();
        drain("s4");
        check("s4_drop", {124'd0, drop0}, 132'd1);
        check("s4_tags", {108'd0, acc0[0][131:128], acc0[1][131:128], acc0[2][131:128],
                          acc0[3][131:128], acc0[4][131:128], acc0[5][131:128]}, {108'd0, 24'h233314});
        check("s4_fhdr_burst", {109'd0, acc0[4][49:27]}, 132'd6);

        // Checksum modes with all-ones lanes
        fill_open(24'd0, 2'd0, 12'd0);
        wave(14'd2, 16'd0, 4'd0);
        m_data(gm); send_group(gm);
        m_data(gm); send_group(gm);
        end_fill();
        drain("s5");
        check("s5_sum_csum", acc1[4], {4'd4, 128'h7FFFFFFE_00000FFE_0007FFFE_2C000000});
        check("s5_xor_csum", acc0[4], {4'd4, 128'h00000000_00001000_00080000_2C000002});

        // num_bursts=0 with trig and fill_end together: tags 2,1,4
        fill_open(24'h000005, 2'd1, 12'h001);
        m_wave(14'd0, 16'hF00D, 4'h3);
        m_close();
        num_bursts = 0; pre_trig = 16'hF00D; xadc_alarms = 4'h3;
        trig = 1'b1; fill_end = 1'b1; tick(); trig = 1'b0; fill_end = 1'b0;
        drain("s7");
        check("s7_tags", {120'd0, acc0[0][131:128], acc0[1][131:128], acc0[2][131:128]}, {120'd0, 12'h214});
        check("s7_fhdr_pt_hi", {128'd0, acc0[1][102:99]}, 132'hF);
        check("s7_fhdr_burst", {109'd0, acc0[1][49:27]}, 132'd3);

        // Reset mid-DATA, then a fresh fill
        fill_open(24'h000077, 2'd3, 12'hABC);
        wave(14'd3, 16'd5, 4'd1);
        m_data(ga); send_group(ga);
        tick(); tick();
        rst = 1'b1; tick();
        check("s6_rst_valid", {131'd0, dout_valid0}, 132'd0);
        check("s6_rst_busy", {131'd0, busy0}, 132'd0);
        check("s6_rst_dout", dout0, 132'd0);
        check("s6_rst_ovr", {116'd0, ovr0}, 132'd0);
        rst = 1'b0;
        q0.delete(); q1.delete();
        tick();
        fill_open(24'h000078, 2'd0, 12'hABC);
        wave(14'd1, 16'd0, 4'd0);
        m_data(gb); send_group(gb);
        end_fill();
        drain("s6");
        check("s6_whdr_wfm", {109'd0, acc0[0][74:52]}, 132'd0);
        check("s6_tags", {116'd0, acc0[0][131:128], acc0[1][131:128], acc0[2][131:128],
                          acc0[3][131:128]}, {116'd0, 16'h2314});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
